// File: rtl/pipelined_ram.sv
// Synchronous single-port RAM with a valid/ready request channel and a read response pipeline.
// A post-reset fill writes INIT_VAL to every word before any request is accepted.
module pipelined_ram #(
    parameter int unsigned       ADDR_W   = 10,
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       RD_LAT   = 1,    // 1 or 2
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic              enable,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy
);

    localparam int unsigned   DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic {
        StInit = 1'b0,
        StIdle = 1'b1
    } state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic [ADDR_W:0]     r_init_cnt;
    logic                w_init_we;

    logic                w_accept;
    logic                w_wr;
    logic                w_rd;
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_wdata;

    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                r_vld1;
    logic [DATA_W-1:0]   r_rdata1;

    // ------------------------------------------------------------------
    // Init FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= StInit;
            r_init_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == StInit) begin
                r_init_cnt <= r_init_cnt + (ADDR_W + 1)'(1);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StInit: begin
                if (r_init_cnt == LAST_ADDR) begin
                    w_state_next = StIdle;
                end
            end
            StIdle: w_state_next = StIdle;
            default: w_state_next = StInit;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        req_ready = 1'b0;
        w_init_we = 1'b0;
        unique case (r_state)
            StInit: begin
                busy      = 1'b1;
                w_init_we = 1'b1;
            end
            StIdle: req_ready = enable;
            default: busy = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Request decode and memory write port
    // ------------------------------------------------------------------
    assign w_accept = req_valid && req_ready;
    assign w_wr     = w_accept && req_we;
    assign w_rd     = w_accept && !req_we;

    // Init and requests never overlap since req_ready is low during the fill.
    assign w_mem_we    = w_init_we || w_wr;
    assign w_mem_addr  = w_init_we ? r_init_cnt[ADDR_W-1:0] : req_addr;
    assign w_mem_wdata = w_init_we ? INIT_VAL : req_wdata;

    always_ff @(posedge CLOCK_50) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline; data registers only move with a valid so rdata holds
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_vld1   <= 1'b0;
            r_rdata1 <= '0;
        end else begin
            r_vld1 <= w_rd;
            if (w_rd) begin
                r_rdata1 <= r_mem[req_addr];
            end
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic              r_vld2;
        logic [DATA_W-1:0] r_rdata2;

        always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
            if (!RESET_N) begin
                r_vld2   <= 1'b0;
                r_rdata2 <= '0;
            end else begin
                r_vld2 <= r_vld1;
                if (r_vld1) begin
                    r_rdata2 <= r_rdata1;
                end
            end
        end

        assign rsp_valid = r_vld2;
        assign rsp_rdata = r_rdata2;
    end else begin : g_lat1
        assign rsp_valid = r_vld1;
        assign rsp_rdata = r_rdata1;
    end

endmodule

// File: tb/tb_pipelined_ram.sv
// Randomised and directed bench for pipelined_ram; runs RD_LAT=1 and RD_LAT=2 instances
// side by side against an array/queue reference model.
module tb_pipelined_ram;

    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 2 ** AW;
    localparam logic [7:0]  IV    = 8'h5A;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          valid = 1'b0;
    logic          we = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;

    logic          rdy1, rv1, busy1;
    logic [DW-1:0] rd1;
    logic          rdy2, rv2, busy2;
    logic [DW-1:0] rd2;

    always #5 clk = ~clk;

    pipelined_ram #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .INIT_VAL(IV)) u_dut_l1 (
        .CLOCK_50  (clk),
        .RESET_N   (rst_n),
        .enable    (en),
        .req_valid (valid),
        .req_ready (rdy1),
        .req_we    (we),
        .req_addr  (addr),
        .req_wdata (wdata),
        .rsp_valid (rv1),
        .rsp_rdata (rd1),
        .busy      (busy1)
    );

    pipelined_ram #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .INIT_VAL(IV)) u_dut_l2 (
        .CLOCK_50  (clk),
        .RESET_N   (rst_n),
        .enable    (en),
        .req_valid (valid),
        .req_ready (rdy2),
        .req_we    (we),
        .req_addr  (addr),
        .req_wdata (wdata),
        .rsp_valid (rv2),
        .rsp_rdata (rd2),
        .busy      (busy2)
    );

    // Reference model: word array, init countdown, and per-latency response queues.
    typedef struct {
        int         due;
        logic [7:0] data;
    } rsp_t;

    logic [7:0] ref_mem [DEPTH];
    rsp_t       q1[$];
    rsp_t       q2[$];
    logic [7:0] last1, last2;
    int         init_left;
    int         cyc;
    int         n_checks;
    int         n_pass;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic check_outputs();
        logic e1, e2;
        e1 = (q1.size() > 0) && (q1[0].due == cyc);
        e2 = (q2.size() > 0) && (q2[0].due == cyc);
        if (e1) begin
            last1 = q1[0].data;
            void'(q1.pop_front());
        end
        if (e2) begin
            last2 = q2[0].data;
            void'(q2.pop_front());
        end
        check("rsp_valid_l1", 8'(rv1), 8'(e1));
        check("rsp_rdata_l1", rd1, last1);
        check("rsp_valid_l2", 8'(rv2), 8'(e2));
        check("rsp_rdata_l2", rd2, last2);
        check("busy_l1", 8'(busy1), 8'(init_left > 0));
        check("busy_l2", 8'(busy2), 8'(init_left > 0));
    endtask

    // One clock of stimulus; entered and left at a falling edge.
    task automatic step(input logic v, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic e);
        logic acc;
        rsp_t r;
        valid = v;
        we    = w;
        addr  = a;
        wdata = d;
        en    = e;
        #1;
        check("req_ready_l1", 8'(rdy1), 8'(e && (init_left == 0)));
        check("req_ready_l2", 8'(rdy2), 8'(e && (init_left == 0)));
        acc = v && e && (init_left == 0);
        @(posedge clk);
        cyc++;
        if (init_left > 0) init_left--;
        if (acc) begin
            if (w) begin
                ref_mem[a] = d;
            end else begin
                r.data = ref_mem[a];
                r.due  = cyc;
                q1.push_back(r);
                r.due  = cyc + 1;
                q2.push_back(r);
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b1);
    endtask

    task automatic rand_step();
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
             DW'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0));
    endtask

    // Assert reset between edges, check reset outputs, release on a falling edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_rsp_valid_l1", 8'(rv1), 8'd0);
        check("rst_rsp_valid_l2", 8'(rv2), 8'd0);
        check("rst_req_ready_l1", 8'(rdy1), 8'd0);
        check("rst_req_ready_l2", 8'(rdy2), 8'd0);
        check("rst_busy_l1", 8'(busy1), 8'd1);
        check("rst_busy_l2", 8'(busy2), 8'd1);
        check("rst_rdata_l1", rd1, 8'd0);
        check("rst_rdata_l2", rd2, 8'd0);
        q1.delete();
        q2.delete();
        last1     = '0;
        last2     = '0;
        init_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = IV;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_init();
        int n;
        n = 0;
        while (busy1 && n < 100) begin
            rand_step();
            n++;
        end
        check("init_cycles", 8'(n), 8'(DEPTH));
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        valid    = 1'b1;
        en       = 1'b1;
        @(negedge clk);
        do_reset();
        run_init();

        // Every word holds the init value.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, AW'(i), '0, 1'b1);
        idle(3);

        // Basic write/read.
        step(1'b1, 1'b1, 4'd0, 8'd85, 1'b1);
        step(1'b1, 1'b1, 4'd2, 8'd30, 1'b1);
        step(1'b1, 1'b0, 4'd0, '0, 1'b1);
        step(1'b1, 1'b0, 4'd2, '0, 1'b1);
        idle(3);

        // Pipelined reads out of order.
        for (int i = 1; i <= 3; i++) step(1'b1, 1'b1, AW'(i), DW'(i), 1'b1);
        step(1'b1, 1'b0, 4'd3, '0, 1'b1);
        step(1'b1, 1'b0, 4'd1, '0, 1'b1);
        step(1'b1, 1'b0, 4'd2, '0, 1'b1);
        idle(3);

        // Read immediately after write.
        step(1'b1, 1'b1, 4'd6, 8'd97, 1'b1);
        step(1'b1, 1'b0, 4'd6, '0, 1'b1);
        idle(3);

        // Enable gating, then drop enable right after a read accept.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'd6, 8'h00, 1'b0);
        step(1'b1, 1'b0, 4'd6, '0, 1'b1);
        step(1'b1, 1'b1, 4'd6, 8'hEE, 1'b0);
        step(1'b1, 1'b0, 4'd6, '0, 1'b0);
        step(1'b1, 1'b0, 4'd6, '0, 1'b1);
        idle(3);

        for (int i = 0; i < 300; i++) rand_step();
        idle(3);

        // Reset with reads in flight; contents come back as the init value.
        step(1'b1, 1'b1, 4'd9, 8'hC3, 1'b1);
        step(1'b1, 1'b1, 4'd10, 8'h3C, 1'b1);
        step(1'b1, 1'b0, 4'd9, '0, 1'b1);
        step(1'b1, 1'b0, 4'd10, '0, 1'b1);
        do_reset();
        run_init();
        step(1'b1, 1'b0, 4'd9, '0, 1'b1);
        step(1'b1, 1'b0, 4'd10, '0, 1'b1);
        idle(3);

        for (int i = 0; i < 200; i++) rand_step();
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipelined_ram.md
Name: pipelined_ram

Overview:
- Parametrised, synchronous single-port RAM. Replaces the earlier switch-gated, tristate, asynchronous-read RAM used by the VGA path.
- Separate write-data and read-data buses; no tristate.
- Valid/ready request channel and a response channel whose read latency is configurable.
- After reset, a hardware init FSM fills every word with a constant. Clients therefore never see undefined contents.

Parameters:
- ADDR_W, 10, address width; depth = 2**ADDR_W words.
- DATA_W, 8, word width in bits.
- RD_LAT, 1, read latency in cycles from request accept to rsp_valid; legal values are 1 or 2 only.
- INIT_VAL, 0, DATA_W-bit value written to every word during init.

Ports:
- CLOCK_50  in  1  system clock; all logic is on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- enable  in  1  access gate, successor of the old switch gate; requests are refused while low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle pulse; rsp_rdata is valid in that cycle.
- rsp_rdata  out  DATA_W  read data.
- busy  out  1  init fill in progress.

Behaviour:
- Reset (RESET_N low, asynchronous): state=INIT, init counter=0, read pipeline flushed.
  - Output values during reset: req_ready=0, rsp_valid=0, rsp_rdata=0, busy=1.
  - Memory contents are not cleared by reset itself; the INIT fill overwrites them.
- FSM has two states, INIT and IDLE.
  - INIT: each cycle, write INIT_VAL to mem[init_cnt] and increment init_cnt. After the write to address 2**ADDR_W-1, go to IDLE.
  - INIT takes exactly 2**ADDR_W cycles after reset release. busy falls in the first IDLE cycle.
  - init_cnt is ADDR_W+1 bits so the terminal count cannot wrap silently.
  - IDLE is terminal until the next reset.
  - enable has no effect on INIT; the fill always completes.
- req_ready = (state==IDLE) && enable. This is combinational from registered state and the enable input.
- A request is accepted on a rising edge where req_valid && req_ready.
- Write accept:
  - mem[req_addr] <= req_wdata at that edge.
  - No response is generated.
- Read accept:
  - rsp_valid pulses high exactly RD_LAT cycles after the accept edge.
  - rsp_rdata = mem[req_addr] as sampled at the accept edge.
  - RD_LAT=2 adds one output register stage.
- Throughput: one request per cycle, with any mix of reads and writes.
  - Back-to-back reads are fully pipelined; responses return in request order, one per cycle.
- Hazards:
  - Only one request can be accepted per cycle, so there is no same-cycle read/write collision.
  - A read accepted the cycle after a write to the same address returns the new data.
- No response backpressure: the consumer must take rsp_rdata in the rsp_valid cycle.
- rsp_rdata holds its last value when rsp_valid=0. It is only guaranteed meaningful while rsp_valid=1.
- enable falling while reads are in flight: outstanding reads still complete. Only new accepts are blocked.
- Reset mid-operation:
  - In-flight reads are dropped and no rsp_valid is produced for them.
  - INIT restarts from address 0.
  - A write accepted on the same edge as reset assertion is not guaranteed to land.
- Out-of-range address: not possible, since depth is exactly 2**ADDR_W.

Test Plan:
- Init: ADDR_W=4, INIT_VAL=8'h5A; release RESET_N -> busy=1 and req_ready=0 for exactly 16 cycles, then busy=0. Read addresses 0..15 with enable=1 -> every rsp_rdata=8'h5A.
- Write/read: after init, write 85 to addr 0 and 30 to addr 2, then read addr 0 and addr 2 -> rsp_valid pulses RD_LAT cycles after each read accept with data 85, then 30. Run once with RD_LAT=1 and once with RD_LAT=2.
- Pipelined reads: write 1, 2, 3 to addrs 1..3; issue reads to addrs 3, 1, 2 on consecutive cycles -> rsp_valid high for 3 consecutive cycles with data 3, 1, 2.
- Read-after-write: write 97 to addr 6, then read addr 6 on the next cycle -> response data=97.
- Enable gating: hold enable=0 with req_valid=1 -> req_ready=0, memory unchanged, no rsp_valid. Drop enable the cycle after a read accept -> that response still arrives with correct data.
- Mid-operation reset: issue reads, then assert RESET_N low before the responses arrive -> rsp_valid=0 immediately; after release busy=1 for 2**ADDR_W cycles; subsequent reads return INIT_VAL at the previously written addresses.
